dispense_monitor: RTL

Closed-loop dispense confirmation for one pill compartment. On a one-cycle dispense request from the schedule logic, it drives the motor GPIO for a fixed pulse, then watches the raw beam-break sensor GPIO (input side of GPIO_0) for a pill drop. It retries on timeout and latches a fault after exhausting retries. It is the receiving and acknowledging end of the dispense output path and sits between the dispense-time FSM and the GPIO pins.

---
 rtl/dispense_monitor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dispense_monitor.sv
// Closed-loop dispense confirmation for one pill compartment: pulses the motor,
// watches a debounced beam-break sensor for a drop, retries, and latches a fault.
module dispense_monitor #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES  = 100000000,
    parameter int MAX_RETRIES     = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       request,
    input  logic       sensor_n,
    input  logic       fault_clear,
    output logic       motor,
    output logic       busy,
    output logic       confirmed,
    output logic       fault,
    output logic       spurious,
    output logic [7:0] drop_count
);

    localparam logic [31:0] DEB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] PULSE_LAST   = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  MAX_R        = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        WAIT    = 3'd2,
        CONFIRM = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sync1;
    logic        sync2;
    logic        deb;
    logic        drop_ev;
    logic [31:0] deb_cnt;
    logic [31:0] timer;
    logic [7:0]  attempts;
    logic        attempt_clr;
    logic        attempt_inc;

    // Sensor path: synchronizer, then a debouncer that accepts a new level only
    // after it has been stable for DEBOUNCE_CYCLES; drop_ev marks a 1->0 accept.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_cnt <= 32'd0;
            drop_ev <= 1'b0;
        end else begin
            sync1   <= sensor_n;
            sync2   <= sync1;
            drop_ev <= 1'b0;
            if (sync2 != deb) begin
                if (deb_cnt == DEB_LAST) begin
                    deb     <= sync2;
                    deb_cnt <= 32'd0;
                    drop_ev <= deb;
                end else begin
                    deb_cnt <= deb_cnt + 32'd1;
                end
            end else begin
                deb_cnt <= 32'd0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        attempt_clr = 1'b0;
        attempt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    state_next  = DRIVE;
                    attempt_clr = 1'b1;
                end
            end
            DRIVE: begin
                if (drop_ev) begin
                    state_next = CONFIRM;
                end else if (timer == PULSE_LAST) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A drop on the terminal-count cycle still counts as success.
                if (drop_ev) begin
                    state_next = CONFIRM;
                end else if (timer == TIMEOUT_LAST) begin
                    if (attempts < MAX_R) begin
                        state_next  = DRIVE;
                        attempt_inc = 1'b1;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            CONFIRM: begin
                state_next = IDLE;
            end
            FAULT: begin
                if (fault_clear) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The shared timer restarts on every state change and only runs while timing.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= 32'd0;
            attempts <= 8'd0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= 32'd0;
            end else if (state == DRIVE || state == WAIT) begin
                timer <= timer + 32'd1;
            end
            if (attempt_clr) begin
                attempts <= 8'd0;
            end else if (attempt_inc) begin
                attempts <= attempts + 8'd1;
            end
        end
    end

    // All outputs are registered from the current state, one cycle behind it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            motor      <= 1'b0;
            busy       <= 1'b0;
            confirmed  <= 1'b0;
            fault      <= 1'b0;
            spurious   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            motor     <= (state == DRIVE);
            busy      <= (state != IDLE) && (state != FAULT);
            confirmed <= (state == CONFIRM);
            fault     <= (state == FAULT);
            spurious  <= drop_ev && ((state == IDLE) || (state == FAULT));
            if (state == CONFIRM && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule
